// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-wide SPI master.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam int SPI_MODE   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_GAP,
    ST_LAG,
    ST_TRAIL
  } spi_state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider: toggles SCK every CLK_DIV enabled cycles, reports which edge the next clock makes.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic restart_i,
  output logic sck_o,
  output logic rise_en_o,
  output logic fall_en_o
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          tick;

  // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    tick  = enable_i && !restart_i && (cnt_q == CNT_TERM);
    if (restart_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (enable_i) begin
      if (tick) begin
        cnt_d = '0;
        sck_d = ~sck_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o     = sck_q;
  assign rise_en_o = tick & ~sck_q;
  assign fall_en_o = tick & sck_q;

endmodule

// File: rtl/spi_byte_master.sv
// Mode-0, MSB-first SPI byte master with valid/ready byte input and pulsed byte output.
module spi_byte_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 4
) (
  input  logic                  CLOCK_Y2,
  input  logic                  RESET_N,
  input  logic [SPI_BYTE_W-1:0] TX_DATA,
  input  logic                  TX_VALID,
  input  logic                  TX_LAST,
  output logic                  TX_READY,
  output logic [SPI_BYTE_W-1:0] RX_DATA,
  output logic                  RX_VALID,
  output logic                  BUSY,
  output logic                  SCK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic                  SS
);

  localparam int WAIT_MAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
  localparam int WW       = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] LAG_TERM   = WW'(CLK_DIV - 1);
  localparam logic [WW-1:0] TRAIL_TERM = WW'(SS_GAP - 2);

  spi_state_e            state_q, state_d;
  logic [SPI_BYTE_W-1:0] tx_q, tx_d;
  logic [SPI_BYTE_W-1:0] rx_sr_q, rx_sr_d;
  logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  last_q, last_d;
  logic                  ss_q, ss_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic                  sck_en, sck_restart, rise_en, fall_en;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk       (CLOCK_Y2),
    .rst_n     (RESET_N),
    .enable_i  (sck_en),
    .restart_i (sck_restart),
    .sck_o     (SCK),
    .rise_en_o (rise_en),
    .fall_en_o (fall_en)
  );

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    last_d      = last_q;
    ss_d        = ss_q;
    bit_cnt_d   = bit_cnt_q;
    wait_d      = wait_q;
    sck_en      = 1'b0;
    sck_restart = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (TX_VALID) begin
          tx_d        = TX_DATA;
          last_d      = TX_LAST;
          ss_d        = 1'b0;
          bit_cnt_d   = '0;
          sck_restart = 1'b1;
          state_d     = ST_LEAD;
        end
      end
      ST_LEAD: begin
        sck_en = 1'b1;
        if (rise_en) begin
          rx_sr_d = {rx_sr_q[SPI_BYTE_W-2:0], MISO};
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sck_en = 1'b1;
        if (rise_en) rx_sr_d = {rx_sr_q[SPI_BYTE_W-2:0], MISO};
        if (fall_en) begin
          if (bit_cnt_q == 4'd7) begin
            // Last fall: MOSI holds, the assembled byte is published for one cycle.
            bit_cnt_d  = 4'd8;
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            wait_d     = '0;
            state_d    = last_q ? ST_LAG : ST_GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = {tx_q[SPI_BYTE_W-2:0], 1'b0};
          end
        end
      end
      ST_LAG: begin
        if (wait_q == LAG_TERM) begin
          ss_d    = 1'b1;
          wait_d  = '0;
          // The IDLE cycle that accepts the next byte is the final SS-high cycle of the gap.
          state_d = (SS_GAP > 1) ? ST_TRAIL : ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_TRAIL: begin
        if (wait_q == TRAIL_TERM) state_d = ST_IDLE;
        else                      wait_d  = wait_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_Y2 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      last_q     <= 1'b0;
      ss_q       <= 1'b1;
      bit_cnt_q  <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      last_q     <= last_d;
      ss_q       <= ss_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_q     <= wait_d;
    end
  end

  assign TX_READY = (state_q == ST_IDLE) || (state_q == ST_GAP);
  assign BUSY     = (state_q != ST_IDLE);
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign MOSI     = tx_q[SPI_BYTE_W-1];
  assign SS       = ss_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: CLK_DIV=4 unit with a mode-0 slave model, CLK_DIV=1 unit with MISO low.
module tb_spi_byte_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] tx_data0, tx_data1, rx_data0, rx_data1;
  logic       tx_valid0, tx_last0, tx_ready0, rx_valid0, busy0, sck0, mosi0, miso0, ss0;
  logic       tx_valid1, tx_last1, tx_ready1, rx_valid1, busy1, sck1, mosi1, miso1, ss1;

  spi_byte_master #(.CLK_DIV(4), .SS_GAP(4)) dut0 (
    .CLOCK_Y2(clk), .RESET_N(rst_n), .TX_DATA(tx_data0), .TX_VALID(tx_valid0), .TX_LAST(tx_last0),
    .TX_READY(tx_ready0), .RX_DATA(rx_data0), .RX_VALID(rx_valid0), .BUSY(busy0), .SCK(sck0),
    .MOSI(mosi0), .MISO(miso0), .SS(ss0));

  spi_byte_master #(.CLK_DIV(1), .SS_GAP(4)) dut1 (
    .CLOCK_Y2(clk), .RESET_N(rst_n), .TX_DATA(tx_data1), .TX_VALID(tx_valid1), .TX_LAST(tx_last1),
    .TX_READY(tx_ready1), .RX_DATA(rx_data1), .RX_VALID(rx_valid1), .BUSY(busy1), .SCK(sck1),
    .MOSI(mosi1), .MISO(miso1), .SS(ss1));

  assign miso1 = 1'b0;

  // Mode-0 slave: bit 7 out at SS fall, next bit on each SCK fall, next byte after 8 falls.
  logic [7:0] sl_arr [4];
  logic [7:0] sl_sr = 8'h00;
  int         sl_idx = 0;
  int         sl_bits = 0;
  assign miso0 = sl_sr[7];

  always @(negedge ss0) begin
    sl_bits = 0;
    sl_sr   = sl_arr[sl_idx % 4];
  end

  always @(negedge sck0) begin
    if (ss0 === 1'b0) begin
      sl_bits++;
      if (sl_bits == 8) begin
        sl_bits = 0;
        sl_idx++;
        sl_sr = sl_arr[sl_idx % 4];
      end else begin
        sl_sr = sl_sr << 1;
      end
    end
  end

  logic [7:0] mosi_cap0 = 8'h00, mosi_cap1 = 8'h00;
  int rises0 = 0, ss_rise0 = 0, rxv0 = 0, rxv1 = 0;
  always @(posedge sck0) begin mosi_cap0 = {mosi_cap0[6:0], mosi0}; rises0++; end
  always @(posedge sck1) mosi_cap1 = {mosi_cap1[6:0], mosi1};
  always @(posedge ss0) ss_rise0++;
  always @(posedge clk) begin
    if (rx_valid0 === 1'b1) rxv0++;
    if (rx_valid1 === 1'b1) rxv1++;
  end

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int which, input logic [7:0] d, input logic last);
    int n = 0;
    while (((which == 0) ? tx_ready0 : tx_ready1) !== 1'b1 && n < 500) begin tick(); n++; end
    check("tx_ready_wait", 32'(n < 500), 32'd1);
    if (which == 0) begin tx_data0 = d; tx_last0 = last; tx_valid0 = 1'b1; end
    else            begin tx_data1 = d; tx_last1 = last; tx_valid1 = 1'b1; end
    tick();
    tx_valid0 = 1'b0;
    tx_valid1 = 1'b0;
  endtask

  task automatic wait_rxv0(output int n);
    n = 0;
    while (rx_valid0 !== 1'b1 && n < 2000) begin tick(); n++; end
    check("rx_valid0_wait", 32'(n < 2000), 32'd1);
  endtask

  task automatic wait_ss0_high(output int n);
    n = 0;
    while (ss0 !== 1'b1 && n < 500) begin tick(); n++; end
    check("ss0_high_wait", 32'(n < 500), 32'd1);
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (busy0 !== 1'b0 && n < 500) begin tick(); n++; end
    check("idle0_wait", 32'(n < 500), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, r0, s0, v0, viol, h, rdy;
    logic [15:0] sckv;
    logic [7:0]  frame_tx [3];
    logic [7:0]  frame_rx [3];
    frame_tx = '{8'h01, 8'h02, 8'h03};
    frame_rx = '{8'h81, 8'h42, 8'hC3};
    sl_arr   = '{8'h00, 8'h00, 8'h00, 8'h00};
    rst_n = 1'b0;
    tx_data0 = 8'h00; tx_valid0 = 1'b0; tx_last0 = 1'b0;
    tx_data1 = 8'h00; tx_valid1 = 1'b0; tx_last1 = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_ss",       {31'd0, ss0},       32'd1);
    check("rst_sck",      {31'd0, sck0},      32'd0);
    check("rst_mosi",     {31'd0, mosi0},     32'd0);
    check("rst_tx_ready", {31'd0, tx_ready0}, 32'd1);
    check("rst_rx_valid", {31'd0, rx_valid0}, 32'd0);
    check("rst_rx_data",  {24'd0, rx_data0},  32'h00);
    check("rst_busy",     {31'd0, busy0},     32'd0);
    check("rst_ss1",      {31'd0, ss1},       32'd1);
    rst_n = 1'b1;
    tick();

    // Single byte A5 out, 3C back
    sl_arr = '{8'h3C, 8'h00, 8'h00, 8'h00}; sl_idx = 0;
    r0 = rises0; v0 = rxv0;
    send(0, 8'hA5, 1'b1);
    check("single_ss_low",    {31'd0, ss0},   32'd0);
    check("single_mosi_bit7", {31'd0, mosi0}, 32'd1);
    check("single_tx_ready",  {31'd0, tx_ready0}, 32'd0);
    wait_rxv0(n);
    check("single_latency",   n,                 32'd64);
    check("single_rx_data",   {24'd0, rx_data0}, 32'h3C);
    check("single_mosi_bits", {24'd0, mosi_cap0}, 32'hA5);
    check("single_rises",     rises0 - r0,        32'd8);
    wait_ss0_high(n);
    check("single_lag",       n,                  32'd4);
    check("single_trail_busy",  {31'd0, busy0},     32'd1);
    check("single_trail_ready", {31'd0, tx_ready0}, 32'd0);
    wait_idle0();
    check("single_rxv_pulses", rxv0 - v0, 32'd1);

    // Three-byte frame
    sl_arr = '{8'h81, 8'h42, 8'hC3, 8'h00}; sl_idx = 0;
    r0 = rises0; s0 = ss_rise0; v0 = rxv0;
    for (int i = 0; i < 3; i++) begin
      send(0, frame_tx[i], (i == 2));
      wait_rxv0(n);
      check("frame_latency",   n,                  32'd64);
      check("frame_rx_data",   {24'd0, rx_data0},  {24'd0, frame_rx[i]});
      check("frame_mosi_bits", {24'd0, mosi_cap0}, {24'd0, frame_tx[i]});
    end
    check("frame_ss_held", ss_rise0 - s0, 32'd0);
    wait_idle0();
    check("frame_rises",      rises0 - r0,   32'd24);
    check("frame_rxv_pulses", rxv0 - v0,     32'd3);
    check("frame_ss_release", ss_rise0 - s0, 32'd1);

    // Stall in GAP for 50 cycles
    sl_arr = '{8'hE7, 8'h18, 8'h00, 8'h00}; sl_idx = 0;
    s0 = ss_rise0;
    send(0, 8'h5A, 1'b0);
    wait_rxv0(n);
    check("gap_rx0", {24'd0, rx_data0}, 32'hE7);
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ss0 !== 1'b0 || sck0 !== 1'b0 || tx_ready0 !== 1'b1) viol++;
    end
    check("gap_hold", viol, 32'd0);
    send(0, 8'hC3, 1'b1);
    wait_rxv0(n);
    check("gap_latency", n,                   32'd64);
    check("gap_rx1",     {24'd0, rx_data0},   32'h18);
    check("gap_mosi1",   {24'd0, mosi_cap0},  32'hC3);
    wait_idle0();
    check("gap_ss_rises", ss_rise0 - s0, 32'd1);

    // CLK_DIV=1, MISO tied low
    v0 = rxv1;
    send(1, 8'hFF, 1'b1);
    check("div1_ss_low", {31'd0, ss1}, 32'd0);
    n = 0; sckv = '0;
    while (rx_valid1 !== 1'b1 && n < 200) begin
      tick();
      if (n < 16) sckv[n] = sck1;
      n++;
    end
    check("div1_latency", n,                   32'd16);
    check("div1_sck_seq", {16'd0, sckv},       32'h5555);
    check("div1_rx_data", {24'd0, rx_data1},   32'h00);
    check("div1_mosi",    {24'd0, mosi_cap1},  32'hFF);
    tick();
    check("div1_rxv_pulses", rxv1 - v0, 32'd1);

    // Back-to-back frames with TX_VALID held high
    wait_idle0();
    sl_arr = '{8'h96, 8'h69, 8'h00, 8'h00}; sl_idx = 0;
    tx_data0 = 8'h3E; tx_last0 = 1'b1; tx_valid0 = 1'b1;
    tick();
    check("b2b_ss_low", {31'd0, ss0}, 32'd0);
    wait_rxv0(n);
    check("b2b_rx0", {24'd0, rx_data0}, 32'h96);
    wait_ss0_high(n);
    h = 0; rdy = 0;
    while (ss0 === 1'b1 && h < 100) begin
      if (tx_ready0 === 1'b1) rdy++;
      tick();
      h++;
    end
    check("b2b_ss_high_cycles", h,   32'd4);
    check("b2b_ready_cycles",   rdy, 32'd1);
    tx_valid0 = 1'b0;
    wait_rxv0(n);
    check("b2b_rx1",   {24'd0, rx_data0},  32'h69);
    check("b2b_mosi1", {24'd0, mosi_cap0}, 32'h3E);
    wait_idle0();

    // Reset in the middle of SHIFT
    sl_arr = '{8'hAA, 8'h00, 8'h00, 8'h00}; sl_idx = 0;
    send(0, 8'hF0, 1'b1);
    for (int i = 0; i < 29; i++) tick();
    check("midrst_sck_before", {31'd0, sck0}, 32'd1);
    v0 = rxv0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ss",       {31'd0, ss0},       32'd1);
    check("midrst_sck",      {31'd0, sck0},      32'd0);
    check("midrst_mosi",     {31'd0, mosi0},     32'd0);
    check("midrst_tx_ready", {31'd0, tx_ready0}, 32'd1);
    check("midrst_busy",     {31'd0, busy0},     32'd0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) tick();
    check("midrst_no_rxv",  rxv0 - v0,         32'd0);
    check("midrst_rx_data", {24'd0, rx_data0}, 32'h00);
    check("midrst_ss_idle", {31'd0, ss0},      32'd1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
